dac_frame_decoder: RTL and testbench

DAC_FRAME_DECODER -- requirements
Module: dac_frame_decoder

---
 rtl/dac_frame_pkg.sv | 48 ++++
 rtl/dac_report_tx.sv | 117 +++++++++++
 rtl/dac_frame_decoder.sv | 172 +++++++++++++++++
 tb/tb_dac_frame_decoder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_frame_pkg.sv
// -----------------------------------------------------------------------------
// dac_frame_pkg
// Shared definitions for the DAC frame decoder: frame field offsets, command
// encodings, address codes, report FSM state encoding and a channel-select
// helper. Imported by dac_frame_decoder and dac_report_tx.
// -----------------------------------------------------------------------------
package dac_frame_pkg;

  // Frame layout: [23:22] ignored, [21:19] cmd, [18:16] addr, [15:0] data
  localparam int FRAME_W  = 24;
  localparam int CMD_MSB  = 21;
  localparam int CMD_LSB  = 19;
  localparam int ADDR_MSB = 18;
  localparam int ADDR_LSB = 16;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 0;
  localparam int DATA_W   = DATA_MSB - DATA_LSB + 1;

  typedef enum logic [2:0] {
    CMD_WRITE_IR        = 3'd0,  // IR[addr] <= data
    CMD_UPDATE_DR       = 3'd1,  // DR[addr] <= IR[addr]
    CMD_WRITE_UPDATE_ALL = 3'd2, // IR[addr] <= data, then DR <= IR for all
    CMD_WRITE_BOTH      = 3'd3,  // IR[addr], DR[addr] <= data
    CMD_NOP4            = 3'd4,
    CMD_SW_RESET        = 3'd5,  // data[0]=1 resets, data[0]=0 is a no-op
    CMD_LDAC_MASK       = 3'd6,  // mask <= data[3:0]
    CMD_NOP7            = 3'd7
  } cmd_e;

  // Address codes: 0..3 are channels A..D, 7 selects all, 4..6 select none
  localparam logic [2:0] ADDR_CH_A = 3'd0;
  localparam logic [2:0] ADDR_ALL  = 3'd7;

  // Report FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ID   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_LO   = 2'd3;

  // Report ID byte is the ASCII channel letter
  localparam logic [7:0] ID_CHAR_BASE = 8'h41;

  // True when address code 'addr' selects channel 'ch'
  function automatic logic chan_hit(input logic [2:0] addr, input int ch);
    return (addr == ADDR_ALL) || (addr == ADDR_CH_A + 3'(ch));
  endfunction

endpackage

// File: rtl/dac_report_tx.sv
// -----------------------------------------------------------------------------
// dac_report_tx
// Byte-report engine. Keeps a pending set of channels whose DAC register
// changed, pops the lowest pending channel when idle and sends three bytes:
// "A"+ch, DR[15:8], DR[7:0] (value latched at pop). Each byte is strobed for
// one cycle once tx_busy is low, followed by one idle gap cycle.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        software reset: empty pending set, clear overflow, abort report
//   chg          per-channel "DR changes on this edge" flags
//   dr           current DAC registers (sampled at pop)
//   tx_busy      UART transmitter busy
//   tx_data      report byte, held until the next strobe
//   new_tx_data  one-cycle strobe, tx_data valid
//   overflow     sticky: a change hit a channel that was already pending
// -----------------------------------------------------------------------------
module dac_report_tx
  import dac_frame_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic [NUM_CH-1:0]              chg,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  dr,
  input  logic                           tx_busy,
  output logic [7:0]                     tx_data,
  output logic                           new_tx_data,
  output logic                           overflow
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] pend_q;
  logic [NUM_CH-1:0] pop_sel;
  logic [CH_W-1:0]   pop_idx;
  logic [1:0]        state_q;
  logic [1:0]        state_next;
  logic              sent_q;      // current byte already strobed; next cycle is the gap
  logic [CH_W-1:0]   ch_q;
  logic [DATA_W-1:0] val_q;
  logic [7:0]        tx_byte;

  // Lowest pending channel, only offered while idle. Scanning downward lets
  // the lowest index win.
  always_comb begin
    pop_sel = '0;
    pop_idx = '0;
    if (state_q == ST_IDLE) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (pend_q[i]) begin
          pop_sel    = '0;
          pop_sel[i] = 1'b1;
          pop_idx    = CH_W'(i);
        end
      end
    end
  end

  always_comb begin
    tx_byte    = ID_CHAR_BASE + 8'(ch_q);
    state_next = ST_IDLE;
    case (state_q)
      ST_ID: state_next = ST_HI;
      ST_HI: begin
        tx_byte    = val_q[15:8];
        state_next = ST_LO;
      end
      ST_LO: tx_byte = val_q[7:0];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= '0;
      overflow    <= 1'b0;
      state_q     <= ST_IDLE;
      sent_q      <= 1'b0;
      ch_q        <= '0;
      val_q       <= '0;
      tx_data     <= '0;
      new_tx_data <= 1'b0;
    end else begin
      new_tx_data <= 1'b0;
      if (flush) begin
        pend_q   <= '0;
        overflow <= 1'b0;
        state_q  <= ST_IDLE;
        sent_q   <= 1'b0;
      end else begin
        // A channel popped this cycle is no longer pending, so a change on
        // the same edge re-queues it without counting as overflow.
        pend_q <= (pend_q & ~pop_sel) | chg;
        if (|(pend_q & ~pop_sel & chg)) overflow <= 1'b1;

        if (state_q == ST_IDLE) begin
          if (|pop_sel) begin
            ch_q    <= pop_idx;
            val_q   <= dr[pop_idx];
            state_q <= ST_ID;
          end
        end else if (sent_q) begin
          sent_q  <= 1'b0;
          state_q <= state_next;
        end else if (!tx_busy) begin
          new_tx_data <= 1'b1;
          tx_data     <= tx_byte;
          sent_q      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dac_frame_decoder.sv
// -----------------------------------------------------------------------------
// dac_frame_decoder
// Decodes 24-bit DAC command frames into per-channel input registers (IR),
// DAC registers (DR) and LDAC mask bits; a falling edge on ldac_n copies
// IR to DR for unmasked channels. Optional byte reports of DR changes are
// compiled in with macro DAC_FRAME_REPORT_EN; without it tx_data,
// new_tx_data and overflow are tied to 0 and tx_busy is ignored.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   data_mosi     received frame, valid with new_frame
//   new_frame     one-cycle strobe, frame complete
//   ldac_n        load-DAC pin (synchronous), acts on its falling edge
//   rd_ch, rd_val combinational readback of DR[rd_ch]
//   tx_data, new_tx_data, tx_busy  report byte stream to a UART
//   overflow      sticky, a report was dropped
// -----------------------------------------------------------------------------
module dac_frame_decoder
  import dac_frame_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [FRAME_W-1:0]  data_mosi,
  input  logic                new_frame,
  input  logic                ldac_n,
  input  logic [1:0]          rd_ch,
  output logic [DATA_W-1:0]   rd_val,
  output logic [7:0]          tx_data,
  output logic                new_tx_data,
  input  logic                tx_busy,
  output logic                overflow
);

  cmd_e              cmd;
  logic [2:0]        addr;
  logic [DATA_W-1:0] data;
  logic [1:0]        unused_frame_bits;

  assign cmd               = cmd_e'(data_mosi[CMD_MSB:CMD_LSB]);
  assign addr              = data_mosi[ADDR_MSB:ADDR_LSB];
  assign data              = data_mosi[DATA_MSB:DATA_LSB];
  assign unused_frame_bits = data_mosi[FRAME_W-1:CMD_MSB+1];

  logic [NUM_CH-1:0][DATA_W-1:0] ir_q, ir_d, dr_q, dr_d;
  logic [NUM_CH-1:0]             mask_q, mask_d;
  logic [NUM_CH-1:0]             touched;   // channels owned by this frame
  logic                          ldac_q;
  logic                          ldac_fall;
  logic                          soft_rst;

  assign ldac_fall = ldac_q & ~ldac_n;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    ir_d     = ir_q;
    dr_d     = dr_q;
    mask_d   = mask_q;
    touched  = '0;
    soft_rst = 1'b0;

    if (new_frame) begin
      case (cmd)
        CMD_WRITE_IR: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (chan_hit(addr, i)) begin
              ir_d[i]    = data;
              touched[i] = 1'b1;
            end
          end
        end
        CMD_UPDATE_DR: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (chan_hit(addr, i)) begin
              dr_d[i]    = ir_q[i];
              touched[i] = 1'b1;
            end
          end
        end
        CMD_WRITE_UPDATE_ALL: begin
          // Every DR loads, and the addressed IR passes its new value through.
          for (int i = 0; i < NUM_CH; i++) begin
            if (chan_hit(addr, i)) ir_d[i] = data;
            dr_d[i] = ir_d[i];
          end
          touched = '1;
        end
        CMD_WRITE_BOTH: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (chan_hit(addr, i)) begin
              ir_d[i]    = data;
              dr_d[i]    = data;
              touched[i] = 1'b1;
            end
          end
        end
        CMD_SW_RESET:  soft_rst = data[0];
        CMD_LDAC_MASK: mask_d   = data[NUM_CH-1:0];
        default: ;
      endcase
    end

    // LDAC copy for channels the frame does not own; the frame wins on overlap.
    if (ldac_fall) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!touched[i] && !mask_q[i]) dr_d[i] = ir_q[i];
      end
    end

    if (soft_rst) begin
      ir_d   = '0;
      dr_d   = '0;
      mask_d = '0;
    end
  end

  // NOTE: the channel registers are a handful of flops rather than a RAM,
  // so they take the asynchronous reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q   <= '0;
      dr_q   <= '0;
      mask_q <= '0;
      ldac_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      ir_q   <= ir_d;
      dr_q   <= dr_d;
      mask_q <= mask_d;
      ldac_q <= ldac_n;
    end
  end

  assign rd_val = dr_q[rd_ch];

`ifdef DAC_FRAME_REPORT_EN
  logic [NUM_CH-1:0] chg;

  // A software reset zeroes DR but flushes the queue, so it raises no reports.
  always_comb begin
    chg = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      chg[i] = !soft_rst && (dr_d[i] != dr_q[i]);
    end
  end

  dac_report_tx #(
    .NUM_CH (NUM_CH)
  ) u_report (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (soft_rst),
    .chg         (chg),
    .dr          (dr_q),
    .tx_busy     (tx_busy),
    .tx_data     (tx_data),
    .new_tx_data (new_tx_data),
    .overflow    (overflow)
  );
`else
  logic unused_tx_busy;

  assign unused_tx_busy = tx_busy;
  assign tx_data        = '0;
  assign new_tx_data    = 1'b0;
  assign overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_dac_frame_decoder.sv
// -----------------------------------------------------------------------------
// tb_dac_frame_decoder
// Directed scenarios plus a randomized phase against a behavioural model.
// Expected report bytes go into a queue; a negedge monitor pops and compares
// them on every new_tx_data strobe, and compares rd_val / overflow each cycle.
// Report expectations depend on DAC_FRAME_REPORT_EN.
// -----------------------------------------------------------------------------
module tb_dac_frame_decoder;

`ifdef DAC_FRAME_REPORT_EN
  localparam int RPT = 1;
`else
  localparam int RPT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] data_mosi = '0;
  logic        new_frame = 1'b0;
  logic        ldac_n = 1'b1;
  logic [1:0]  rd_ch = '0;
  logic [15:0] rd_val;
  logic [7:0]  tx_data;
  logic        new_tx_data;
  logic        tx_busy = 1'b0;
  logic        overflow;

  int checks   = 0;
  int failures = 0;
  int strobes  = 0;
  int cyc      = 0;
  int last_strobe = -100;
  logic busy_q = 1'b0;

  always #5 clk = ~clk;

  dac_frame_decoder #(.NUM_CH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_mosi   (data_mosi),
    .new_frame   (new_frame),
    .ldac_n      (ldac_n),
    .rd_ch       (rd_ch),
    .rd_val      (rd_val),
    .tx_data     (tx_data),
    .new_tx_data (new_tx_data),
    .tx_busy     (tx_busy),
    .overflow    (overflow)
  );

  // ---------------- reference model ----------------
  logic [15:0] m_ir [4];
  logic [15:0] m_dr [4];
  logic [3:0]  m_mask;
  bit          m_pend [4];
  bit          m_ovf;
  int          m_cnt;        // cycles until the report engine is free
  bit          m_ldac_prev;
  logic [7:0]  exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] mk(input logic [2:0] c, input logic [2:0] a, input logic [15:0] d);
    return {2'b00, c, a, d};
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 4; c++) begin
      m_ir[c]   = '0;
      m_dr[c]   = '0;
      m_pend[c] = 1'b0;
    end
    m_mask = '0;
    m_ovf  = 1'b0;
    m_cnt  = 0;
    exp_q.delete();
  endtask

  task automatic model_reset();
    model_clear();
    m_ldac_prev = 1'b1;
  endtask

  // State after one clock edge that sampled (f, nf, ld).
  task automatic model_step(input logic [23:0] f, input logic nf, input logic ld);
    int          cmd  = int'(f[21:19]);
    int          addr = int'(f[18:16]);
    logic [15:0] d    = f[15:0];
    bit          fall = m_ldac_prev && !ld;
    logic [15:0] ir_n [4];
    logic [15:0] dr_n [4];
    bit          hit [4];
    m_ldac_prev = ld;
    if (m_cnt > 0) m_cnt--;
    if (nf && cmd == 5 && d[0]) begin
      model_clear();
      return;
    end
    // A free engine takes the lowest pending channel; one report spans
    // 3 bytes x (strobe + gap) plus the idle pop cycle = 7 cycles.
    if (m_cnt == 0) begin
      for (int c = 0; c < 4; c++) begin
        if (m_pend[c]) begin
          m_pend[c] = 1'b0;
          if (RPT != 0) begin
            exp_q.push_back(8'(8'h41 + c));
            exp_q.push_back(m_dr[c][15:8]);
            exp_q.push_back(m_dr[c][7:0]);
          end
          m_cnt = 7;
          break;
        end
      end
    end
    for (int c = 0; c < 4; c++) begin
      bit sel;
      ir_n[c] = m_ir[c];
      dr_n[c] = m_dr[c];
      hit[c]  = 1'b0;
      sel     = (addr == 7) || (addr == c);
      if (nf) begin
        case (cmd)
          0: if (sel) begin ir_n[c] = d; hit[c] = 1'b1; end
          1: if (sel) begin dr_n[c] = m_ir[c]; hit[c] = 1'b1; end
          2: begin
            if (sel) ir_n[c] = d;
            dr_n[c] = ir_n[c];
            hit[c]  = 1'b1;
          end
          3: if (sel) begin ir_n[c] = d; dr_n[c] = d; hit[c] = 1'b1; end
          default: ;
        endcase
      end
      if (fall && !hit[c] && !m_mask[c]) dr_n[c] = m_ir[c];
    end
    if (nf && cmd == 6) m_mask = d[3:0];
    for (int c = 0; c < 4; c++) begin
      if (dr_n[c] != m_dr[c]) begin
        if (m_pend[c]) m_ovf = (RPT != 0);
        m_pend[c] = 1'b1;
      end
      m_ir[c] = ir_n[c];
      m_dr[c] = dr_n[c];
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cycle(input logic [23:0] f, input logic nf, input logic ld);
    data_mosi = f;
    new_frame = nf;
    ldac_n    = ld;
    rd_ch     = 2'($urandom_range(0, 3));
    @(posedge clk);
    #1;
    model_step(f, nf, ld);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(data_mosi, 1'b0, ldac_n);
  endtask

  task automatic peek(input logic [1:0] ch, input string name, input logic [15:0] exp);
    rd_ch = ch;
    #1;
    check(name, rd_val, exp);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) busy_q <= tx_busy;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      check("reset_outputs", {rd_val, tx_data, new_tx_data, overflow}, '0);
    end else begin
      check("rd_val", rd_val, m_dr[rd_ch]);
      check("overflow", overflow, m_ovf);
      if (new_tx_data) begin
        strobes++;
        check("strobe_while_busy", busy_q, 1'b0);
        check("strobe_gap_ok", (cyc - last_strobe) >= 2, 1'b1);
        last_strobe = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe: got tx_data=0x%0h expected no strobe at t=%0t", tx_data, $time);
        end else begin
          check("tx_data", tx_data, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int s0;
    logic [2:0]  rc, ra;
    logic [15:0] rdat;
    logic        rnf, rld;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // cmd3 channel A 0x0123: DR A next cycle, reports "A",0x01,0x23
    s0 = strobes;
    cycle(24'h18_0123, 1'b1, 1'b1);
    peek(2'd0, "cmd3_dr_a", 16'h0123);
    idle(12);
    check("cmd3_strobes", strobes - s0, 3 * RPT);

    // cmd0 ch B then LDAC fall: one report
    s0 = strobes;
    cycle(mk(3'd0, 3'd1, 16'hBEEF), 1'b1, 1'b1);
    peek(2'd1, "cmd0_dr_b_held", 16'h0000);
    cycle(24'h0, 1'b0, 1'b0);
    cycle(24'h0, 1'b0, 1'b1);
    peek(2'd1, "ldac_dr_b", 16'hBEEF);
    idle(12);
    check("ldac_strobes", strobes - s0, 3 * RPT);

    // same with mask 0x2: B must ignore LDAC
    s0 = strobes;
    cycle(mk(3'd6, 3'd0, 16'h0002), 1'b1, 1'b1);
    cycle(mk(3'd0, 3'd1, 16'h1234), 1'b1, 1'b1);
    cycle(24'h0, 1'b0, 1'b0);
    cycle(24'h0, 1'b0, 1'b1);
    peek(2'd1, "masked_dr_b", 16'hBEEF);
    idle(12);
    check("masked_strobes", strobes - s0, 0);
    cycle(mk(3'd6, 3'd0, 16'h0000), 1'b1, 1'b1);

    // IR C = 0x0010, then cmd2 to B 0x0050: DR B and C both load, B reported first
    s0 = strobes;
    cycle(mk(3'd0, 3'd2, 16'h0010), 1'b1, 1'b1);
    cycle(mk(3'd2, 3'd1, 16'h0050), 1'b1, 1'b1);
    peek(2'd1, "cmd2_dr_b", 16'h0050);
    peek(2'd2, "cmd2_dr_c", 16'h0010);
    idle(20);
    check("cmd2_strobes", strobes - s0, 6 * RPT);

    // tx_busy held for 100 cycles: no strobe until release
    s0 = strobes;
    tx_busy = 1'b1;
    cycle(mk(3'd3, 3'd3, 16'hCAFE), 1'b1, 1'b1);
    idle(100);
    check("busy_no_strobe", strobes - s0, 0);
    tx_busy = 1'b0;
    idle(20);
    check("busy_release_strobes", strobes - s0, 3 * RPT);

    // ch A updated 3 times while its report runs: overflow, one extra report
    s0 = strobes;
    cycle(mk(3'd3, 3'd0, 16'h1111), 1'b1, 1'b1);
    idle(1);
    cycle(mk(3'd3, 3'd0, 16'h2222), 1'b1, 1'b1);
    cycle(mk(3'd3, 3'd0, 16'h3333), 1'b1, 1'b1);
    cycle(mk(3'd3, 3'd0, 16'h4444), 1'b1, 1'b1);
    check("overflow_set", overflow, 1'(RPT));
    idle(25);
    check("overflow_strobes", strobes - s0, 6 * RPT);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      rc   = 3'($urandom_range(0, 7));
      ra   = 3'($urandom_range(0, 7));
      rdat = 16'($urandom);
      if (rc == 3'd5 && $urandom_range(0, 7) != 0) rdat[0] = 1'b0;
      rnf  = ($urandom_range(0, 2) == 0);
      rld  = ($urandom_range(0, 3) != 0);
      cycle({2'($urandom), rc, ra, rdat}, rnf, rld);
    end
    idle(30);

    // software reset mid-report
    cycle(mk(3'd3, 3'd2, 16'hABCD), 1'b1, 1'b1);
    idle(3);
    s0 = strobes;
    cycle(24'h28_0001, 1'b1, 1'b1);
    peek(2'd0, "swrst_dr_a", 16'h0000);
    peek(2'd2, "swrst_dr_c", 16'h0000);
    check("swrst_overflow", overflow, 1'b0);
    idle(1);
    peek(2'd1, "swrst_dr_b", 16'h0000);
    peek(2'd3, "swrst_dr_d", 16'h0000);
    idle(20);
    check("swrst_no_strobe", strobes - s0, 0);

    // hardware reset mid-report
    cycle(mk(3'd3, 3'd1, 16'h5A5A), 1'b1, 1'b1);
    idle(3);
    s0 = strobes;
    rst_n     = 1'b0;
    new_frame = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    peek(2'd1, "hwrst_dr_b", 16'h0000);
    rst_n = 1'b1;
    idle(20);
    check("hwrst_no_strobe", strobes - s0, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
